// File: rtl/i2c_target_pkg.sv
// Shared types and constants for the I2C target engine.
// Imported by the bus synchronizer and the target core.
package i2c_target_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDR     = 3'd1,
        ST_ADDR_ACK = 3'd2,
        ST_WR_BYTE  = 3'd3,
        ST_WR_ACK   = 3'd4,
        ST_RD_LOAD  = 3'd5,
        ST_RD_BYTE  = 3'd6,
        ST_RD_ACK   = 3'd7
    } state_t;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    localparam int CNT_W = 3;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronizer with one history flop.
// Decodes SCL edges and START/STOP conditions.
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic aclk,
    input  logic aresetn,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);

    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_hist;
    logic                   r_sda_hist;

    // Idle bus is high, so everything resets to 1.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_hist <= 1'b1;
            r_sda_hist <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_in};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_in};
            r_scl_hist <= r_scl_sync[SYNC_STAGES-1];
            r_sda_hist <= r_sda_sync[SYNC_STAGES-1];
        end
    end

    assign scl      = r_scl_sync[SYNC_STAGES-1];
    assign sda      = r_sda_sync[SYNC_STAGES-1];
    assign scl_rise = scl & ~r_scl_hist;
    assign scl_fall = ~scl & r_scl_hist;
    assign start    = scl & r_scl_hist & r_sda_hist & ~sda;
    assign stop     = scl & r_scl_hist & ~r_sda_hist & sda;

endmodule

// File: rtl/i2c_target_core.sv
// I2C target engine: address match, write byte stream out,
// read byte stream in, open-drain SDA drive.
module i2c_target_core
    import i2c_target_pkg::*;
#(
    parameter logic [6:0] OWN_ADDR    = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       aclk,
    input  logic       aresetn,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       start_det,
    output logic       stop_det,
    output logic       tx_underrun
);

    logic w_scl;
    logic w_sda;
    logic w_scl_rise;
    logic w_scl_fall;
    logic w_start;
    logic w_stop;

    i2c_bus_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .aclk    (aclk),
        .aresetn (aresetn),
        .scl_in  (scl_in),
        .sda_in  (sda_in),
        .scl     (w_scl),
        .sda     (w_sda),
        .scl_rise(w_scl_rise),
        .scl_fall(w_scl_fall),
        .start   (w_start),
        .stop    (w_stop)
    );

    state_t           r_state, n_state;
    logic [CNT_W-1:0] r_cnt, n_cnt;
    logic [7:0]       r_shift, n_shift;
    logic             r_rw, n_rw;
    logic             r_phase, n_phase;
    logic             r_acked, n_acked;
    logic             r_sda_oe, n_sda_oe;
    logic             r_busy, n_busy;
    logic [7:0]       r_rx_data, n_rx_data;
    logic             r_rx_valid, n_rx_valid;
    logic             r_tx_ready, n_tx_ready;
    logic             r_start_det, n_start_det;
    logic             r_stop_det, n_stop_det;
    logic             r_underrun, n_underrun;

    logic       w_rise;
    logic       w_fall;
    logic [7:0] w_shift_in;
    logic [7:0] w_load_byte;
    logic       w_wr_resp;
    logic       w_do_load;

    assign w_rise      = w_scl_rise & w_scl;
    assign w_fall      = w_scl_fall;
    assign w_shift_in  = {r_shift[6:0], w_sda};
    assign w_load_byte = tx_valid ? tx_data : 8'hFF;
    assign w_wr_resp   = rx_ready ? ACK : NACK;

    // Read bytes are loaded on the very fall that opens the bit slot.
    assign w_do_load = w_fall & ~w_start & ~w_stop &
                       ((r_state == ST_RD_LOAD) |
                        ((r_state == ST_ADDR_ACK) & r_phase & r_rw));

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state     <= ST_IDLE;
            r_cnt       <= CNT_MAX;
            r_shift     <= 8'h00;
            r_rw        <= 1'b0;
            r_phase     <= 1'b0;
            r_acked     <= 1'b0;
            r_sda_oe    <= 1'b0;
            r_busy      <= 1'b0;
            r_rx_data   <= 8'h00;
            r_rx_valid  <= 1'b0;
            r_tx_ready  <= 1'b0;
            r_start_det <= 1'b0;
            r_stop_det  <= 1'b0;
            r_underrun  <= 1'b0;
        end else begin
            r_state     <= n_state;
            r_cnt       <= n_cnt;
            r_shift     <= n_shift;
            r_rw        <= n_rw;
            r_phase     <= n_phase;
            r_acked     <= n_acked;
            r_sda_oe    <= n_sda_oe;
            r_busy      <= n_busy;
            r_rx_data   <= n_rx_data;
            r_rx_valid  <= n_rx_valid;
            r_tx_ready  <= n_tx_ready;
            r_start_det <= n_start_det;
            r_stop_det  <= n_stop_det;
            r_underrun  <= n_underrun;
        end
    end

    always_comb begin
        n_state     = r_state;
        n_cnt       = r_cnt;
        n_shift     = r_shift;
        n_rw        = r_rw;
        n_phase     = r_phase;
        n_acked     = r_acked;
        n_sda_oe    = r_sda_oe;
        n_busy      = r_busy;
        n_rx_data   = r_rx_data;
        n_rx_valid  = 1'b0;
        n_tx_ready  = 1'b0;
        n_start_det = 1'b0;
        n_stop_det  = 1'b0;
        n_underrun  = r_underrun;

        if (w_start) begin
            n_state     = ST_ADDR;
            n_cnt       = CNT_MAX;
            n_shift     = 8'h00;
            n_phase     = 1'b0;
            n_sda_oe    = 1'b0;
            n_start_det = 1'b1;
            n_underrun  = 1'b0;
        end else if (w_stop) begin
            n_state    = ST_IDLE;
            n_sda_oe   = 1'b0;
            n_busy     = 1'b0;
            n_stop_det = 1'b1;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                end
                ST_ADDR: begin
                    if (w_rise) begin
                        n_shift = w_shift_in;
                        if (r_cnt != '0) begin
                            n_cnt = r_cnt - 1'b1;
                        end else if (w_shift_in[7:1] == OWN_ADDR) begin
                            n_state = ST_ADDR_ACK;
                            n_busy  = 1'b1;
                            n_rw    = w_shift_in[0];
                            n_phase = 1'b0;
                        end else begin
                            n_state = ST_IDLE;
                            n_busy  = 1'b0;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (w_fall) begin
                        if (!r_phase) begin
                            n_sda_oe = ~ACK;
                            n_phase  = 1'b1;
                        end else if (!r_rw) begin
                            n_sda_oe = 1'b0;
                            n_state  = ST_WR_BYTE;
                            n_cnt    = CNT_MAX;
                            n_phase  = 1'b0;
                        end
                    end
                end
                ST_WR_BYTE: begin
                    if (w_rise) begin
                        n_shift = w_shift_in;
                        if (r_cnt == '0) n_phase = 1'b1;
                        else             n_cnt   = r_cnt - 1'b1;
                    end else if (w_fall && r_phase) begin
                        n_rx_data  = r_shift;
                        n_rx_valid = 1'b1;
                        n_acked    = rx_ready;
                        n_sda_oe   = ~w_wr_resp;
                        n_state    = ST_WR_ACK;
                    end
                end
                ST_WR_ACK: begin
                    if (w_fall) begin
                        n_sda_oe = 1'b0;
                        if (r_acked) begin
                            n_state = ST_WR_BYTE;
                            n_cnt   = CNT_MAX;
                            n_phase = 1'b0;
                        end else begin
                            n_state = ST_IDLE;
                            n_busy  = 1'b0;
                        end
                    end
                end
                ST_RD_LOAD: begin
                end
                ST_RD_BYTE: begin
                    if (w_fall) begin
                        if (r_cnt == '0) begin
                            n_sda_oe = 1'b0;
                            n_state  = ST_RD_ACK;
                        end else begin
                            n_shift  = {r_shift[6:0], 1'b0};
                            n_sda_oe = ~r_shift[6];
                            n_cnt    = r_cnt - 1'b1;
                        end
                    end
                end
                ST_RD_ACK: begin
                    if (w_rise) begin
                        if (w_sda == ACK) begin
                            n_state = ST_RD_LOAD;
                        end else begin
                            n_state = ST_IDLE;
                            n_busy  = 1'b0;
                        end
                    end
                end
                default: n_state = ST_IDLE;
            endcase

            if (w_do_load) begin
                n_shift    = w_load_byte;
                n_sda_oe   = ~w_load_byte[7];
                n_cnt      = CNT_MAX;
                n_state    = ST_RD_BYTE;
                n_tx_ready = tx_valid;
                if (!tx_valid) n_underrun = 1'b1;
            end
        end
    end

    assign sda_oe      = r_sda_oe;
    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign tx_ready    = r_tx_ready;
    assign busy        = r_busy;
    assign start_det   = r_start_det;
    assign stop_det    = r_stop_det;
    assign tx_underrun = r_underrun;

endmodule

// File: doc/i2c_target_core.md
# i2c_target_core

I2C target (slave) engine, the responder counterpart of the SoC's I2C master controller. It watches SCL/SDA, detects START/STOP, matches a 7-bit own address, and acknowledges. It shifts write bytes out to a byte-stream receive port and read bytes in from a byte-stream transmit port. It sits behind a CSR/AXI-Lite wrapper or drives a local register file directly; SDA output is open-drain (drive-low enable only).

## Interface
- `OWN_ADDR`, default 7'h50: 7-bit address this target responds to.
- `SYNC_STAGES`, default 2: synchronizer depth on SCL/SDA inputs; legal range 2..3.
- `aclk` input 1: system clock; must be ≥ 20× SCL frequency.
- `aresetn` input 1: asynchronous, active-low reset.
- `scl_in` input 1: raw SCL pin level.
- `sda_in` input 1: raw SDA pin level.
- `sda_oe` output 1: 1 pulls SDA low, 0 releases it. Reset 0.
- `rx_data` output 8: received write byte. Reset 8'h00.
- `rx_valid` output 1: one-cycle pulse, `rx_data` valid. Reset 0.
- `rx_ready` input 1: sampled at the ACK decision; 0 means NACK this byte.
- `tx_data` input 8: byte to return on a read.
- `tx_valid` input 1: `tx_data` available.
- `tx_ready` output 1: one-cycle pulse, `tx_data` consumed. Reset 0.
- `busy` output 1: addressed transaction in progress (address matched until STOP/NACK). Reset 0.
- `start_det` output 1: one-cycle pulse on START or repeated START. Reset 0.
- `stop_det` output 1: one-cycle pulse on STOP. Reset 0.
- `tx_underrun` output 1: sticky flag, set when a read byte was needed with `tx_valid`=0. Cleared by START. Reset 0.

## Operation
- Inputs pass through `SYNC_STAGES` flops, then one history flop.
  - `scl_rise`/`scl_fall` are decoded from sync vs history.
  - START = SDA fall while SCL high. STOP = SDA rise while SCL high.
- States: IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_LOAD, RD_BYTE, RD_ACK.
- START from any state → ADDR, with bit counter = 7 and shift register cleared.
- STOP from any state → IDLE, with `sda_oe`=0 and `busy`=0.
- ADDR: shift SDA MSB-first on each `scl_rise`; 8 bits = addr[6:0] + R/W.
  - Mismatch → IDLE with no ACK, ignoring the bus until the next START.
  - Match → ADDR_ACK, `busy`=1.
- ADDR_ACK:
  - On the `scl_fall` after bit 8, assert `sda_oe`=1.
  - On the next `scl_fall`, release and go to WR_BYTE (W=0) or RD_LOAD (R=1).
- WR_BYTE: shift 8 bits on `scl_rise`. On the 8th `scl_fall`:
  - Pulse `rx_valid` with the byte.
  - ACK (`sda_oe`=1) if `rx_ready`=1; otherwise NACK.
  - Go to WR_ACK.
  - The byte is delivered even when NACKed.
- WR_ACK: on the next `scl_fall`, release SDA.
  - ACKed → WR_BYTE.
  - NACKed → IDLE, `busy`=0.
- RD_LOAD (entered at an `scl_fall`):
  - Load shift from `tx_data` if `tx_valid`; pulse `tx_ready`.
  - Else load 8'hFF and set `tx_underrun`.
  - Drive bit 7 immediately: `sda_oe` = ~bit.
- RD_BYTE: on each `scl_fall`, drive the next bit. After the 8th bit's `scl_fall`, release SDA → RD_ACK.
- RD_ACK: sample SDA on `scl_rise`.
  - 0 (master ACK) → RD_LOAD at the next `scl_fall`.
  - 1 (NACK) → IDLE, `busy`=0.
- No clock stretching: SCL is never driven.
- Simultaneous START detect and `scl_*` edge in one cycle: START wins.
- A repeated START mid-byte aborts the byte: no `rx_valid`, no `tx_ready`.
- Reset mid-transaction releases SDA immediately (asynchronous) and returns to IDLE.

## Timing
- Pin change to internal edge detect: `SYNC_STAGES`+1 aclk cycles (3 at default).
- `sda_oe` changes exactly 1 aclk after the detected `scl_fall`. Worst-case SDA hold is therefore (`SYNC_STAGES`+2) aclk after the true SCL fall.
- `rx_valid`, `tx_ready`, `start_det`, `stop_det` are single-cycle pulses, registered, 1 aclk after the decoding edge.
- `rx_ready` and `tx_valid`/`tx_data` are sampled in the same aclk as the corresponding `scl_fall` detect.
- All outputs are registered.

## Structure
- Package `i2c_target_pkg`: state encoding localparams, `ACK`=1'b0, `NACK`=1'b1, bit counter width 3.
- Sub-module `i2c_bus_sync`: SYNC_STAGES synchronizer + history flop. Outputs: `scl`, `sda`, `scl_rise`, `scl_fall`, `start`, `stop`. Bus idle-high reset value 1.
- Top: FSM, shift register, bit counter, handshake/flag registers.

## Test plan
- Write, addr 0x50: START, 0xA0, 0x3C, 0xC3, STOP with `rx_ready`=1 → ACK on all 3 bytes; `rx_valid` pulses with 0x3C then 0xC3; `stop_det` pulses; `busy` 0 after.
- Address mismatch: START, 0xA2, 0x11 → `sda_oe` never 1; no `rx_valid`; `busy` stays 0.
- Read: START, 0xA1, `tx_data`=0x5A then 0xA5, master ACK then NACK → SDA shows 0x5A then 0xA5; `tx_ready` pulses twice; FSM in IDLE after the NACK.
- Underrun: read with `tx_valid`=0 → byte 0xFF; `tx_underrun`=1; cleared at the next START.
- Backpressure: write 0x77 with `rx_ready`=0 → `rx_valid` with 0x77; NACK (SDA high in the 9th clock); IDLE.
- Repeated START after write addr + 1 byte, then 0xA1 read → `start_det` twice; read proceeds. Assert `aresetn` mid-read → `sda_oe`=0 in the same cycle; `busy`=0.
